// File: rtl/uart_msg_source.sv
// ---------------------------------------------------------------------------
// uart_msg_source
//
// Upstream byte source for one UART transmit lane. Repeatedly presents a
// fixed ASCII banner ("TT<lane> hello\r\n") to the lane serializer over a
// valid/ready handshake. Consecutive messages are separated by a
// programmable idle gap. Completed messages are counted.
//
// Parameters
//   LANE_ID     lane number 0-9, sent as ASCII '0'+LANE_ID in byte 2
//   GAP_CYCLES  idle cycles between the LF transfer and the next byte 0
//               (legal range 1 .. 2^GAP_W-1)
//   GAP_W       width of the gap down-counter
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous, active-high reset
//   run        in   level; 1 = keep sending messages
//   tx_ready   in   serializer accepts a byte on this edge if tx_valid=1
//   tx_valid   out  tx_data holds a byte to send
//   tx_data    out  byte to send (held stable until accepted)
//   busy       out  high whenever the sequencer is not idle
//   msg_count  out  completed messages, wraps at 8 bits
//
// Optional build macro
//   UART_MSG_COUNT_EN  when defined, two uppercase hex digits of msg_count
//                      (snapshotted when byte 0 is presented, high nibble
//                      first) are inserted between 'o' and CR, giving a
//                      13-byte message. When undefined the message is the
//                      plain 11-byte banner and no snapshot register exists.
// ---------------------------------------------------------------------------
module uart_msg_source #(
   parameter int LANE_ID    = 0,
   parameter int GAP_CYCLES = 1000,
   parameter int GAP_W      = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       tx_ready,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic [7:0] msg_count
);

`ifdef UART_MSG_COUNT_EN
   localparam int MSG_LEN = 13;
`else
   localparam int MSG_LEN = 11;
`endif

   localparam logic [3:0]       LAST_IDX  = 4'(MSG_LEN - 1);
   localparam logic [7:0]       BYTE0     = 8'h54;
   localparam logic [7:0]       LANE_CHAR = 8'(8'h30 + LANE_ID);
   // The gap counter counts down to zero inclusive, so loading N-1 gives
   // exactly N idle cycles before byte 0 is presented again.
   localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             tx_valid_q, tx_valid_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             busy_q, busy_d;
   logic [7:0]       msg_count_q, msg_count_d;

   logic             xfer_c;
   logic [3:0]       next_idx_c;
   logic [7:0]       next_byte_c;

`ifdef UART_MSG_COUNT_EN
   logic [7:0]       snap_q, snap_d;

   // Uppercase ASCII hex digit for one nibble.
   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10) begin
         return 8'h30 + {4'h0, n};
      end
      return 8'h37 + {4'h0, n};
   endfunction
`endif

   // A byte is consumed on any edge where it is offered and accepted.
   assign xfer_c     = tx_valid_q & tx_ready;
   assign next_idx_c = idx_q + 4'd1;

   // Banner lookup for the byte that follows the one currently presented.
   // Byte 0 is loaded directly from BYTE0 when a message starts, so this
   // table only needs to cover indices 1 .. LAST_IDX.
   always_comb begin
      next_byte_c = BYTE0;
      case (next_idx_c)
         4'd1:    next_byte_c = 8'h54;
         4'd2:    next_byte_c = LANE_CHAR;
         4'd3:    next_byte_c = 8'h20;
         4'd4:    next_byte_c = 8'h68;
         4'd5:    next_byte_c = 8'h65;
         4'd6:    next_byte_c = 8'h6C;
         4'd7:    next_byte_c = 8'h6C;
         4'd8:    next_byte_c = 8'h6F;
`ifdef UART_MSG_COUNT_EN
         4'd9:    next_byte_c = hex_char(snap_q[7:4]);
         4'd10:   next_byte_c = hex_char(snap_q[3:0]);
         4'd11:   next_byte_c = 8'h0D;
         4'd12:   next_byte_c = 8'h0A;
`else
         4'd9:    next_byte_c = 8'h0D;
         4'd10:   next_byte_c = 8'h0A;
`endif
         default: next_byte_c = BYTE0;
      endcase
   end

   // Next-state and output logic. Every output is computed here and
   // registered below, so tx_ready never reaches an output combinationally.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      gap_d       = gap_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;
      msg_count_d = msg_count_q;
`ifdef UART_MSG_COUNT_EN
      snap_d      = snap_q;
`endif

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d    = SEND;
               idx_d      = 4'd0;
               tx_data_d  = BYTE0;
               tx_valid_d = 1'b1;
`ifdef UART_MSG_COUNT_EN
               snap_d     = msg_count_q;
`endif
            end
         end

         SEND: begin
            // run is deliberately ignored here: a started message always
            // completes and run is only looked at again when the gap ends.
            if (xfer_c) begin
               if (idx_q == LAST_IDX) begin
                  tx_valid_d  = 1'b0;
                  msg_count_d = msg_count_q + 8'd1;
                  gap_d       = GAP_LOAD;
                  state_d     = GAP;
                  // tx_data keeps the LF; it is don't-care while invalid.
               end else begin
                  idx_d     = next_idx_c;
                  tx_data_d = next_byte_c;
               end
            end
         end

         GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GAP_ONE;
            end else if (run) begin
               state_d    = SEND;
               idx_d      = 4'd0;
               tx_data_d  = BYTE0;
               tx_valid_d = 1'b1;
`ifdef UART_MSG_COUNT_EN
               // msg_count already includes the message just finished.
               snap_d     = msg_count_q;
`endif
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
         end
      endcase

      // busy is registered alongside the state so it tracks it exactly.
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 4'd0;
         gap_q       <= '0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         busy_q      <= 1'b0;
         msg_count_q <= 8'h00;
`ifdef UART_MSG_COUNT_EN
         snap_q      <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         busy_q      <= busy_d;
         msg_count_q <= msg_count_d;
`ifdef UART_MSG_COUNT_EN
         snap_q      <= snap_d;
`endif
      end
   end

   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign busy      = busy_q;
   assign msg_count = msg_count_q;

endmodule

// File: doc/uart_msg_source.md
Name: uart_msg_source

Overview:
- Upstream byte source for one UART transmit lane. Streams a fixed ASCII banner to the lane's serializer over a valid/ready handshake.
- Sequencing: repeats the banner with a programmable idle gap between messages and counts completed messages.
- Placement: one instance per tx pin in the top-level wrapper, each instance with its own LANE_ID.

Parameters:
- LANE_ID, 0, lane number 0-9; emitted as ASCII '0'+LANE_ID in byte 2 of the banner.
- GAP_CYCLES, 1000, idle cycles between messages; legal range 1 to 2^GAP_W-1.
- GAP_W, 16, width of the gap down-counter.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- run  input  1  level; 1 = keep sending messages
- tx_ready  input  1  serializer can accept a byte this cycle
- tx_valid  output  1  tx_data holds a byte to send
- tx_data  output  8  byte to send
- busy  output  1  high whenever the state is not IDLE
- msg_count  output  8  number of completed messages, wraps at 8 bits

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous and active-high.
- Reset values: state=IDLE, tx_valid=0, tx_data=0x00, busy=0, msg_count=0x00, byte index=0, gap counter=0.
- Reset applied mid-message or mid-gap aborts immediately. tx_valid is 0 in the cycle after the reset edge. No partial message is resumed.
- Banner, 11 bytes in order: 'T'(0x54) 'T'(0x54) '0'+LANE_ID ' '(0x20) 'h'(0x68) 'e'(0x65) 'l'(0x6C) 'l'(0x6C) 'o'(0x6F) CR(0x0D) LF(0x0A).
- All outputs are registered. Handshake rule: a transfer occurs on any rising edge where tx_valid=1 and tx_ready=1.
- While tx_valid=1 and no transfer has occurred, tx_data is held stable and tx_valid stays high. tx_ready has no combinational path to any output.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - On an edge with run=1: go to SEND, index=0, tx_data=byte0, tx_valid=1.
  - First valid byte therefore appears 1 cycle after run is sampled high.
- SEND, on a transfer of a byte that is not the last: index+1, tx_data=next byte, tx_valid stays 1. Back-to-back transfers at 1 byte/cycle are supported.
- SEND, on the transfer of the last byte (LF):
  - tx_valid=0, msg_count+1 (0xFF wraps to 0x00).
  - Gap counter loaded with GAP_CYCLES-1; go to GAP.
- GAP:
  - Gap counter nonzero: decrement.
  - Gap counter zero and run=1: go to SEND with byte0 and tx_valid=1.
  - Gap counter zero and run=0: go to IDLE.
  - Net effect: tx_valid is low for exactly GAP_CYCLES cycles between the LF transfer and the next byte0 presentation.
- run deasserted during SEND: the current message always completes; it is never truncated. run is next examined at the end of the gap.
- run deasserted during GAP: no effect until the gap ends; then go to IDLE.
- tx_data after the last transfer: keeps the last byte (LF) while tx_valid=0. Consumers must ignore tx_data whenever tx_valid=0.
- busy = (state != IDLE), registered together with the state.

Optional Feature:
- Macro: UART_MSG_COUNT_EN.
- Defined: two uppercase ASCII hex digits are inserted between 'o' and CR, giving a 13-byte message.
  - Digits encode msg_count as snapshotted when byte0 is presented, high nibble first.
  - Nibble encoding: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46.
  - The first message after reset therefore carries "00".
- Not defined: 11-byte banner only, and no snapshot register is synthesized.

Test Plan:
- Reset, then run=1 with tx_ready=1 held constantly:
  - tx_valid rises 1 cycle after run is sampled high.
  - 11 consecutive transfers 54 54 30 20 68 65 6C 6C 6F 0D 0A (LANE_ID=0).
  - msg_count goes to 0x01 on the LF edge.
  - tx_valid is then low for exactly GAP_CYCLES cycles (use GAP_CYCLES=5) before the next 0x54.
- Backpressure: random tx_ready at about 50% duty:
  - tx_data never changes while tx_valid=1 and tx_ready=0.
  - The received byte sequence is identical to the 11-byte banner.
  - No bytes are dropped or duplicated.
- run dropped at byte index 3:
  - The remaining 8 bytes are still sent.
  - After the gap the state is IDLE: busy=0, tx_valid=0.
  - Re-asserting run restarts at byte0 0x54.
- Reset asserted mid-message at index 6:
  - Next cycle: tx_valid=0, busy=0, msg_count=0x00.
  - After release with run=1, the message restarts from 0x54.
- Wrap test with UART_MSG_COUNT_EN defined, LANE_ID=7, GAP_CYCLES=1:
  - Byte 2 = 0x37 in every message.
  - Message 1 carries "00" (0x30 0x30); message 11 carries "0A" (0x30 0x41).
  - After 256 messages msg_count=0x00, and the 257th message carries "00".
- Macro undefined: message length is exactly 11 bytes. With GAP_CYCLES=1, tx_valid is low for exactly 1 cycle between LF and the next 0x54.
